// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner: FSM state,
// the all-off segment pattern and the active-low hex glyph table.
package seven_seg_pkg;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low, bit 0 = segment a ... bit 6 = segment g; b and d are lowercase.
    localparam logic [6:0] GLYPHS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPHS[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with per-slot blanking,
// once-per-frame input snapshot, leading-zero suppression and digit masking.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 6_000_000,
    parameter int REFRESH_HZ   = 60,
    parameter int BLANK_CYCLES = 64,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int DWELL = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CW    = $clog2(DWELL);
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    // With no blanking requested a slot starts lit immediately.
    localparam scan_state_t SLOT_ENTRY   = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seven_seg_scanner: NUM_DIGITS must be in 1..8");
    end
    if (DWELL <= BLANK_CYCLES) begin : g_bad_dwell
        $error("seven_seg_scanner: DWELL must exceed BLANK_CYCLES");
    end

    scan_state_t             state, state_next;
    logic [CW-1:0]           cnt, cnt_next;
    logic [IW-1:0]           idx, idx_next;
    logic                    armed;
    logic                    take_snap;
    logic [4*NUM_DIGITS-1:0] snap_digits, snap_digits_next;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_next;
    logic [NUM_DIGITS-1:0]   snap_en, snap_en_next;
    logic [NUM_DIGITS-1:0]   suppressed;
    logic                    zero_run;
    logic [3:0]              nibble;
    logic [6:0]              glyph;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;

    seven_seg_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Outputs are computed from the next-cycle state and snapshot so the
    // pins change on the same edge as the FSM.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        take_snap  = 1'b0;
        if (!armed) begin
            take_snap  = 1'b1;
            state_next = SLOT_ENTRY;
        end else if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = SLOT_ENTRY;
            if (idx == IDX_LAST) begin
                idx_next  = '0;
                take_snap = 1'b1;
            end else begin
                idx_next = idx + 1'b1;
            end
        end else begin
            cnt_next = cnt + 1'b1;
            if (state == BLANK && cnt == BLANK_LAST) begin
                state_next = SHOW;
            end
        end

        snap_digits_next = take_snap ? digits   : snap_digits;
        snap_dp_next     = take_snap ? dp_in    : snap_dp;
        snap_en_next     = take_snap ? digit_en : snap_en;

        suppressed = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (snap_digits_next[4*i +: 4] == 4'h0);
            suppressed[i] = zero_run && (i != 0) && (LZ_SUPPRESS != 0);
        end

        nibble   = snap_digits_next[4*idx_next +: 4];
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        an_next  = '1;
        if (state_next == SHOW && snap_en_next[idx_next]) begin
            an_next[idx_next] = 1'b0;
            dp_next           = ~snap_dp_next[idx_next];
            if (!suppressed[idx_next]) begin
                seg_next = glyph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            armed       <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            armed       <= 1'b1;
            snap_digits <= snap_digits_next;
            snap_dp     <= snap_dp_next;
            snap_en     <= snap_en_next;
            seg         <= seg_next;
            dp          <= dp_next;
            an          <= an_next;
            frame_start <= take_snap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios plus random
// input changes, compared every cycle against a frame/slot arithmetic model.
module tb_seven_seg_scanner;

    localparam int N     = 4;
    localparam int DWELL = 5;
    localparam int BLANK = 1;
    localparam int FRAME = N * DWELL;

    logic        clk;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int          vectors;
    int          miscompares;
    int          t;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic [3:0]  prev_an;

    // Active-high gfedcba patterns; the pins are the inverse.
    logic [6:0] hex_on [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seven_seg_scanner #(
        .NUM_DIGITS   (N),
        .CLK_HZ       (1000),
        .REFRESH_HZ   (50),
        .BLANK_CYCLES (BLANK),
        .LZ_SUPPRESS  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits      (digits),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        digits   = d;
        dp_in    = p;
        digit_en = e;
    endtask

    task automatic check_output();
        int         slot;
        int         pos;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       fs_e;
        logic [3:0] nib;
        an_e  = 4'hF;
        seg_e = 7'h7F;
        dp_e  = 1'b1;
        fs_e  = 1'b0;
        if (t >= 0) begin
            slot = (t / DWELL) % N;
            pos  = t % DWELL;
            fs_e = (t % FRAME) == 0;
            if (pos >= BLANK && m_en[slot]) begin
                an_e[slot] = 1'b0;
                dp_e       = ~m_dp[slot];
                nib        = 4'((m_digits >> (4 * slot)) & 16'hF);
                if (!(slot != 0 && (m_digits >> (4 * slot)) == 16'h0)) begin
                    seg_e = ~hex_on[nib];
                end
            end
        end
        vectors++;
        assert (an === an_e) else begin
            miscompares++;
            $error("[TB] FAIL an t=%0d got %b expected %b", t, an, an_e);
        end
        assert (seg === seg_e) else begin
            miscompares++;
            $error("[TB] FAIL seg t=%0d got %b expected %b", t, seg, seg_e);
        end
        assert (dp === dp_e) else begin
            miscompares++;
            $error("[TB] FAIL dp t=%0d got %b expected %b", t, dp, dp_e);
        end
        assert (frame_start === fs_e) else begin
            miscompares++;
            $error("[TB] FAIL frame_start t=%0d got %b expected %b", t, frame_start, fs_e);
        end
        assert ($countones(~an) <= 1) else begin
            miscompares++;
            $error("[TB] FAIL an_onehot t=%0d got %b expected at most one low", t, an);
        end
        assert (!(prev_an != 4'hF && an != 4'hF && an != prev_an)) else begin
            miscompares++;
            $error("[TB] FAIL an_gap t=%0d got %b after %b expected a blank cycle between", t, an, prev_an);
        end
        prev_an = an;
    endtask

    // Advance one clock: update the model with what the DUT sampled, then
    // check the registered outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            t        = -1;
            m_digits = '0;
            m_dp     = '0;
            m_en     = '0;
        end else begin
            t++;
            if (t % FRAME == 0) begin
                m_digits = digits;
                m_dp     = dp_in;
                m_en     = digit_en;
            end
        end
        @(negedge clk);
        check_output();
    endtask

    task automatic run_to_phase(input int phase);
        int budget;
        budget = 2 * FRAME;
        while ((t < 0 || t % FRAME != phase) && budget > 0) begin
            step();
            budget--;
        end
        vectors++;
        assert (budget > 0) else begin
            miscompares++;
            $error("[TB] FAIL phase_wait got timeout expected phase %0d", phase);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = -1;
        m_digits    = '0;
        m_dp        = '0;
        m_en        = '0;
        prev_an     = 4'hF;
        reset       = 1'b0;
        apply_stimulus(16'h1234, 4'b0000, 4'b1111);
        repeat (3) step();

        $display("[TB] reset release with 1234");
        reset = 1'b1;
        repeat (2 * FRAME + 5) step();

        $display("[TB] mid-frame change to 5678");
        run_to_phase(11);
        apply_stimulus(16'h5678, 4'b0000, 4'b1111);
        repeat (2 * FRAME) step();

        $display("[TB] leading zeros 0040 with dp on digit 3");
        run_to_phase(FRAME - 1);
        apply_stimulus(16'h0040, 4'b1000, 4'b1111);
        repeat (FRAME + 1) step();

        $display("[TB] all zeros");
        run_to_phase(FRAME - 1);
        apply_stimulus(16'h0000, 4'b0000, 4'b1111);
        repeat (FRAME + 1) step();

        $display("[TB] digit_en 0101");
        run_to_phase(FRAME - 1);
        apply_stimulus(16'h9ABC, 4'b0011, 4'b0101);
        repeat (2 * FRAME + 1) step();

        $display("[TB] reset mid-SHOW of slot 2");
        apply_stimulus(16'h1234, 4'b0000, 4'b1111);
        run_to_phase(2 * DWELL + 2);
        pulse_reset();
        repeat (FRAME + 5) step();

        $display("[TB] random stimulus");
        for (int k = 0; k < 40; k++) begin
            logic [15:0] d;
            d = 16'($urandom) >> (4 * $urandom_range(0, 4));
            apply_stimulus(d, 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                pulse_reset();
            end
            repeat ($urandom_range(1, 25)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised time-multiplexed driver for N common-segment seven-segment digits. Slices the clock into equal per-digit slots, inserts a blanking gap between digits to prevent ghosting, and snapshots the display value once per frame so digits never tear. Leading zeros can be suppressed and individual digits masked off. Sits between the value-producing logic (switch sums, counters) and the board pins, and replaces the fixed two-digit mux plus separate clock divider.

## Interface
- `NUM_DIGITS`, 4: digits scanned, range 1–8.
- `CLK_HZ`, 6_000_000: frequency of `clk`.
- `REFRESH_HZ`, 60: full-frame rate.
- `BLANK_CYCLES`, 64: all-off cycles at the start of every slot.
- `LZ_SUPPRESS`, 1: 1 blanks leading zeros.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `digits` in 4*NUM_DIGITS: hex nibbles. Digit i is `digits[4i+3:4i]`. Digit 0 is least significant.
- `dp_in` in NUM_DIGITS: decimal-point request per digit.
- `digit_en` in NUM_DIGITS: 1 = digit may light. 0 = slot runs dark.
- `seg` out 7: segments a..g, active-low, bit 0 = a.
- `dp` out 1: decimal point, active-low.
- `an` out NUM_DIGITS: digit enables, active-low. At most one is low at any time.
- `frame_start` out 1: one-cycle pulse on the cycle the snapshot is taken.

## Operation
- `DWELL = CLK_HZ / (REFRESH_HZ*NUM_DIGITS)`, integer division.
- Elaboration error if `DWELL <= BLANK_CYCLES` or `NUM_DIGITS` is outside 1–8.
- Slot counter `cnt` has width `$clog2(DWELL)`. Digit index `idx` has width `max(1,$clog2(NUM_DIGITS))`.
- FSM states:
  - BLANK: `an` all 1, `seg`/`dp` all 1. After `BLANK_CYCLES` cycles go to SHOW.
  - SHOW: drive digit `idx`. When `cnt == DWELL-1`, reset `cnt`, advance `idx` and go to BLANK.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Snapshot: `digits`, `dp_in` and `digit_en` are copied into internal registers on the cycle `idx` wraps to 0, and on the first cycle after reset releases. `frame_start` pulses that same cycle. Input changes mid-frame have no effect until the next frame.
- Leading-zero suppression, computed on the snapshot when `LZ_SUPPRESS=1`:
  - Digit i is suppressed if every digit j ≥ i is 0 and i ≠ 0.
  - Digit 0 always shows.
  - `dp` still lights on a suppressed digit if its `dp_in` bit is set.
- In SHOW:
  - `an[idx]` is low only if snapshot `digit_en[idx]` is 1.
  - `seg` is the decoded nibble, or all 1 if the digit is suppressed or disabled.
  - `dp` is low when snapshot `dp_in[idx]` is 1 and the digit is enabled.
- A disabled digit keeps its full slot time, so brightness of the other digits does not change.
- Decode uses the full hex glyph set 0–F (b and d lowercase).

## Timing
- All outputs are registered and update on the same edge as the state change; no combinational path from inputs to pins.
- Reset, whenever sampled low (mid-slot or mid-frame included), forces on the next edge:
  - state BLANK, `cnt`=0, `idx`=0;
  - `an`, `seg` and `dp` all 1;
  - `frame_start`=0;
  - snapshot registers cleared to 0.
- The first edge with `reset`=1 takes the snapshot and pulses `frame_start`. `an[0]` falls `BLANK_CYCLES` cycles later.
- Each slot is exactly `DWELL` cycles: `BLANK_CYCLES` dark, then `DWELL-BLANK_CYCLES` lit. A frame is `NUM_DIGITS*DWELL` cycles.
- `frame_start` pulses recur every frame at the start of slot 0's BLANK.
- With `NUM_DIGITS=1`, `idx` stays 0 and every slot is a frame.

## Structure
- Package `seven_seg_pkg` holds:
  - the state enum `scan_state_t` {BLANK, SHOW};
  - `SEG_OFF = 7'b1111111`;
  - the 16-entry glyph constant array.
- Sub-module `seven_seg_decode`: combinational nibble→active-low segments using the package array. Instantiated once, fed from the snapshot mux.
- Prescale, FSM, snapshot and suppression logic live in the top module.

## Test plan
All scenarios use `CLK_HZ=1000`, `REFRESH_HZ=50`, `NUM_DIGITS=4`, `BLANK_CYCLES=1`, giving `DWELL=5`.
- Reset release, `digits=16'h1234`, all enabled:
  - `an` all 1 for 1 cycle, then `an=4'b1110` with `seg` = glyph 4 for 4 cycles;
  - then blank 1 cycle, then `an=4'b1101` with glyph 3;
  - `frame_start` every 20 cycles.
- `digits` changes from `16'h1234` to `16'h5678` during slot 2: digits 2 and 3 still show 2 and 1; the next frame shows 8,7,6,5.
- `LZ_SUPPRESS=1`, `digits=16'h0040`, `dp_in=4'b1000`:
  - slot 0 shows 0, slot 1 shows 4;
  - slot 2: `an` low with `seg`=SEG_OFF;
  - slot 3: `seg`=SEG_OFF with `dp`=0.
- `digits=16'h0000`: only digit 0 shows 0.
- `digit_en=4'b0101`: `an` goes low only in slots 0 and 2; slots 1 and 3 stay dark for 5 cycles each; frame stays 20 cycles.
- `reset` low for 1 cycle mid-SHOW of slot 2: all outputs go high on the next edge, and the sequence restarts exactly as in the first scenario.
- Every scenario: assert `an` is never more than one-hot-low, and that at least one all-1 `an` cycle occurs between consecutive digits.
